// File: rtl/conv_t3d_pkg.sv
// Shared types and elaboration-time helpers for the 3D transposed-convolution tap scheduler.
// All functions are constant functions evaluated while parameters are resolved.
package conv_t3d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int out_size(input int in_s, input int str, input int pad,
                                    input int k, input int opad);
        return (in_s - 1) * str - 2 * pad + k + opad;
    endfunction

    function automatic int stride_log2(input int str);
        return $clog2(str);
    endfunction

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int temp_w(input int o, input int k, input int pad);
        return $clog2(((o > k) ? o : k) + pad) + 2;
    endfunction

    function automatic bit stride_ok(input int str);
        return (str == 1) || (str == 2) || (str == 4) || (str == 8);
    endfunction

    // The input index must also fit the positive range of the signed axis temp.
    function automatic bit axis_ok(input int in_s, input int str, input int pad,
                                   input int k, input int opad);
        int o;
        o = out_size(in_s, str, pad, k, opad);
        return stride_ok(str) && (opad >= 0) && (opad < str) && (pad >= 0) &&
               (in_s > 0) && (k > 0) && (o > 0) &&
               (in_s < (1 << (temp_w(o, k, pad) - 1)));
    endfunction

    function automatic bit fits(input longint n, input int aw);
        return n <= (longint'(1) << aw);
    endfunction

endpackage

// File: rtl/conv_t3d_axis_map.sv
// Maps one output coordinate and kernel offset onto an input coordinate for a
// strided, padded transposed convolution axis; off-grid or off-stride taps are invalid.
module conv_t3d_axis_map
    import conv_t3d_pkg::*;
#(
    parameter int IN  = 2,
    parameter int STR = 2,
    parameter int PAD = 1,
    parameter int O   = 4,
    parameter int K   = 3,
    parameter int OBW = cnt_w(O),
    parameter int KBW = cnt_w(K),
    parameter int TW  = temp_w(O, K, PAD)
) (
    input  logic [OBW-1:0] i_o,
    input  logic [KBW-1:0] i_k,
    output logic           o_valid,
    output logic [TW-1:0]  o_i
);

    localparam int            LS   = stride_log2(STR);
    localparam logic [TW-1:0] MASK = TW'(STR - 1);
    localparam logic [TW-1:0] IN_T = TW'(IN);

    logic signed [TW-1:0] w_t;
    logic signed [TW-1:0] w_q;
    logic                 w_valid;

    assign w_t = $signed(TW'(i_o)) + $signed(TW'(PAD)) - $signed(TW'(i_k));
    assign w_q = w_t >>> LS;

    // Negative t is rejected before the quotient is trusted as an index.
    assign w_valid = !w_t[TW-1] && ((w_t & MASK) == '0) && ($unsigned(w_q) < IN_T);

    assign o_valid = w_valid;
    assign o_i     = w_valid ? $unsigned(w_q) : '0;

endmodule

// File: rtl/conv_t3d_tap_scheduler.sv
// Loop-nest sequencer for the grouped 3D transposed convolution: streams one
// (input, weight, output) address triple per candidate tap over valid/ready.
module conv_t3d_tap_scheduler
    import conv_t3d_pkg::*;
#(
    parameter int C_IN   = 4,
    parameter int C_OUT  = 4,
    parameter int GROUPS = 2,
    parameter int IN_D   = 2,
    parameter int IN_H   = 3,
    parameter int IN_W   = 4,
    parameter int K_D    = 3,
    parameter int K_H    = 2,
    parameter int K_W    = 3,
    parameter int STR_D  = 2,
    parameter int STR_H  = 1,
    parameter int STR_W  = 2,
    parameter int PAD_D  = 1,
    parameter int PAD_H  = 0,
    parameter int PAD_W  = 1,
    parameter int OPAD_D = 1,
    parameter int OPAD_H = 0,
    parameter int OPAD_W = 1,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          tap_valid,
    input  logic          tap_ready,
    output logic          tap_en,
    output logic          tap_last,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] wt_addr,
    output logic [AW-1:0] out_addr
);

    localparam int ICG = C_IN / GROUPS;
    localparam int OCG = C_OUT / GROUPS;
    localparam int OD  = out_size(IN_D, STR_D, PAD_D, K_D, OPAD_D);
    localparam int OH  = out_size(IN_H, STR_H, PAD_H, K_H, OPAD_H);
    localparam int OW  = out_size(IN_W, STR_W, PAD_W, K_W, OPAD_W);

    localparam int G_W   = cnt_w(GROUPS);
    localparam int OCL_W = cnt_w(OCG);
    localparam int OD_W  = cnt_w(OD);
    localparam int OH_W  = cnt_w(OH);
    localparam int OW_W  = cnt_w(OW);
    localparam int ICL_W = cnt_w(ICG);
    localparam int KD_W  = cnt_w(K_D);
    localparam int KH_W  = cnt_w(K_H);
    localparam int KW_W  = cnt_w(K_W);
    localparam int TD_W  = temp_w(OD, K_D, PAD_D);
    localparam int TH_W  = temp_w(OH, K_H, PAD_H);
    localparam int TW_W  = temp_w(OW, K_W, PAD_W);

    localparam logic [G_W-1:0]   G_MAX   = G_W'(GROUPS - 1);
    localparam logic [OCL_W-1:0] OCL_MAX = OCL_W'(OCG - 1);
    localparam logic [OD_W-1:0]  OD_MAX  = OD_W'(OD - 1);
    localparam logic [OH_W-1:0]  OH_MAX  = OH_W'(OH - 1);
    localparam logic [OW_W-1:0]  OW_MAX  = OW_W'(OW - 1);
    localparam logic [ICL_W-1:0] ICL_MAX = ICL_W'(ICG - 1);
    localparam logic [KD_W-1:0]  KD_MAX  = KD_W'(K_D - 1);
    localparam logic [KH_W-1:0]  KH_MAX  = KH_W'(K_H - 1);
    localparam logic [KW_W-1:0]  KW_MAX  = KW_W'(K_W - 1);

    localparam bit PARAMS_OK =
        (GROUPS > 0) && (C_IN % GROUPS == 0) && (C_OUT % GROUPS == 0) &&
        axis_ok(IN_D, STR_D, PAD_D, K_D, OPAD_D) &&
        axis_ok(IN_H, STR_H, PAD_H, K_H, OPAD_H) &&
        axis_ok(IN_W, STR_W, PAD_W, K_W, OPAD_W) &&
        fits(longint'(C_IN) * IN_D * IN_H * IN_W, AW) &&
        fits(longint'(C_IN) * OCG * K_D * K_H * K_W, AW) &&
        fits(longint'(C_OUT) * OD * OH * OW, AW);

    if (!PARAMS_OK) begin : g_param_check
        $error("conv_t3d_tap_scheduler: illegal parameter combination");
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;
    logic   w_done;

    // The output-channel loop is kept as a (group, channel-in-group) pair,
    // which avoids dividing oc by OCG.
    logic [G_W-1:0]   r_g;
    logic [OCL_W-1:0] r_ocl;
    logic [OD_W-1:0]  r_od;
    logic [OH_W-1:0]  r_oh;
    logic [OW_W-1:0]  r_ow;
    logic [ICL_W-1:0] r_icl;
    logic [KD_W-1:0]  r_kd;
    logic [KH_W-1:0]  r_kh;
    logic [KW_W-1:0]  r_kw;

    logic          r_last_loaded;
    logic          r_tap_valid;
    logic          r_tap_en;
    logic          r_tap_last;
    logic [AW-1:0] r_in_addr;
    logic [AW-1:0] r_wt_addr;
    logic [AW-1:0] r_out_addr;

    logic w_g_max, w_ocl_max, w_od_max, w_oh_max, w_ow_max;
    logic w_icl_max, w_kd_max, w_kh_max, w_kw_max;
    logic w_cy_kh, w_cy_kd, w_cy_icl, w_cy_ow, w_cy_oh, w_cy_od, w_cy_ocl, w_cy_g;
    logic w_all_max;
    logic w_load;
    logic w_final;

    logic            w_vd, w_vh, w_vw, w_en;
    logic [TD_W-1:0] w_id;
    logic [TH_W-1:0] w_ih;
    logic [TW_W-1:0] w_iw;
    logic [AW-1:0]   w_oc, w_ic;
    logic [AW-1:0]   w_in_addr, w_wt_addr, w_out_addr;

    assign w_g_max   = (r_g   == G_MAX);
    assign w_ocl_max = (r_ocl == OCL_MAX);
    assign w_od_max  = (r_od  == OD_MAX);
    assign w_oh_max  = (r_oh  == OH_MAX);
    assign w_ow_max  = (r_ow  == OW_MAX);
    assign w_icl_max = (r_icl == ICL_MAX);
    assign w_kd_max  = (r_kd  == KD_MAX);
    assign w_kh_max  = (r_kh  == KH_MAX);
    assign w_kw_max  = (r_kw  == KW_MAX);

    // Carry into each loop level, innermost (kw) first.
    assign w_cy_kh   = w_kw_max;
    assign w_cy_kd   = w_cy_kh  & w_kh_max;
    assign w_cy_icl  = w_cy_kd  & w_kd_max;
    assign w_cy_ow   = w_cy_icl & w_icl_max;
    assign w_cy_oh   = w_cy_ow  & w_ow_max;
    assign w_cy_od   = w_cy_oh  & w_oh_max;
    assign w_cy_ocl  = w_cy_od  & w_od_max;
    assign w_cy_g    = w_cy_ocl & w_ocl_max;
    assign w_all_max = w_cy_g   & w_g_max;

    assign w_final = (r_state == ST_RUN) && r_last_loaded && r_tap_valid && tap_ready;
    assign w_load  = !abort &&
                     (((r_state == ST_IDLE) && start) ||
                      ((r_state == ST_RUN) && !r_last_loaded && (!r_tap_valid || tap_ready)));

    conv_t3d_axis_map #(
        .IN(IN_D), .STR(STR_D), .PAD(PAD_D), .O(OD), .K(K_D),
        .OBW(OD_W), .KBW(KD_W), .TW(TD_W)
    ) u_axis_d (
        .i_o(r_od), .i_k(r_kd), .o_valid(w_vd), .o_i(w_id)
    );

    conv_t3d_axis_map #(
        .IN(IN_H), .STR(STR_H), .PAD(PAD_H), .O(OH), .K(K_H),
        .OBW(OH_W), .KBW(KH_W), .TW(TH_W)
    ) u_axis_h (
        .i_o(r_oh), .i_k(r_kh), .o_valid(w_vh), .o_i(w_ih)
    );

    conv_t3d_axis_map #(
        .IN(IN_W), .STR(STR_W), .PAD(PAD_W), .O(OW), .K(K_W),
        .OBW(OW_W), .KBW(KW_W), .TW(TW_W)
    ) u_axis_w (
        .i_o(r_ow), .i_k(r_kw), .o_valid(w_vw), .o_i(w_iw)
    );

    assign w_en = w_vd & w_vh & w_vw;

    assign w_oc = AW'(r_g) * AW'(OCG) + AW'(r_ocl);
    assign w_ic = AW'(r_g) * AW'(ICG) + AW'(r_icl);

    assign w_in_addr  = ((w_ic * AW'(IN_D) + AW'(w_id)) * AW'(IN_H) + AW'(w_ih)) * AW'(IN_W)
                        + AW'(w_iw);
    assign w_wt_addr  = (((w_ic * AW'(OCG) + AW'(r_ocl)) * AW'(K_D) + AW'(r_kd)) * AW'(K_H)
                         + AW'(r_kh)) * AW'(K_W) + AW'(r_kw);
    assign w_out_addr = ((w_oc * AW'(OD) + AW'(r_od)) * AW'(OH) + AW'(r_oh)) * AW'(OW)
                        + AW'(r_ow);

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_final) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    // Counters wrap to zero together after the final tap, so IDLE always starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_ocl <= '0;
            r_od  <= '0;
            r_oh  <= '0;
            r_ow  <= '0;
            r_icl <= '0;
            r_kd  <= '0;
            r_kh  <= '0;
            r_kw  <= '0;
        end else if (abort) begin
            r_g   <= '0;
            r_ocl <= '0;
            r_od  <= '0;
            r_oh  <= '0;
            r_ow  <= '0;
            r_icl <= '0;
            r_kd  <= '0;
            r_kh  <= '0;
            r_kw  <= '0;
        end else if (w_load) begin
            r_kw <= w_kw_max ? '0 : r_kw + KW_W'(1);
            if (w_cy_kh)  r_kh  <= w_kh_max  ? '0 : r_kh  + KH_W'(1);
            if (w_cy_kd)  r_kd  <= w_kd_max  ? '0 : r_kd  + KD_W'(1);
            if (w_cy_icl) r_icl <= w_icl_max ? '0 : r_icl + ICL_W'(1);
            if (w_cy_ow)  r_ow  <= w_ow_max  ? '0 : r_ow  + OW_W'(1);
            if (w_cy_oh)  r_oh  <= w_oh_max  ? '0 : r_oh  + OH_W'(1);
            if (w_cy_od)  r_od  <= w_od_max  ? '0 : r_od  + OD_W'(1);
            if (w_cy_ocl) r_ocl <= w_ocl_max ? '0 : r_ocl + OCL_W'(1);
            if (w_cy_g)   r_g   <= w_g_max   ? '0 : r_g   + G_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_loaded <= 1'b0;
            r_tap_valid   <= 1'b0;
            r_tap_en      <= 1'b0;
            r_tap_last    <= 1'b0;
            r_in_addr     <= '0;
            r_wt_addr     <= '0;
            r_out_addr    <= '0;
        end else if (abort) begin
            r_last_loaded <= 1'b0;
            r_tap_valid   <= 1'b0;
            r_tap_en      <= 1'b0;
            r_tap_last    <= 1'b0;
            r_in_addr     <= '0;
            r_wt_addr     <= '0;
            r_out_addr    <= '0;
        end else if (w_load) begin
            r_last_loaded <= w_all_max;
            r_tap_valid   <= 1'b1;
            r_tap_en      <= w_en;
            r_tap_last    <= w_cy_ow;
            r_in_addr     <= w_en ? w_in_addr : '0;
            r_wt_addr     <= w_en ? w_wt_addr : '0;
            r_out_addr    <= w_out_addr;
        end else if (w_final) begin
            r_last_loaded <= 1'b0;
            r_tap_valid   <= 1'b0;
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign tap_valid = r_tap_valid;
    assign tap_en    = r_tap_en;
    assign tap_last  = r_tap_last;
    assign in_addr   = r_in_addr;
    assign wt_addr   = r_wt_addr;
    assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_conv_t3d_tap_scheduler.sv
// Self-checking bench for conv_t3d_tap_scheduler: full-rate, throttled, abort and
// mid-run reset scenarios scored against an index-decoding reference model.
module tb_conv_t3d_tap_scheduler;

    localparam int C_IN = 4, C_OUT = 4, GROUPS = 2;
    localparam int IN_D = 2, IN_H = 3, IN_W = 4;
    localparam int K_D = 3, K_H = 2, K_W = 3;
    localparam int STR_D = 2, STR_H = 1, STR_W = 2;
    localparam int PAD_D = 1, PAD_H = 0, PAD_W = 1;
    localparam int OPAD_D = 1, OPAD_H = 0, OPAD_W = 1;
    localparam int AW = 16;

    localparam int ICG   = C_IN / GROUPS;
    localparam int OCG   = C_OUT / GROUPS;
    localparam int OD    = (IN_D - 1) * STR_D - 2 * PAD_D + K_D + OPAD_D;
    localparam int OH    = (IN_H - 1) * STR_H - 2 * PAD_H + K_H + OPAD_H;
    localparam int OW    = (IN_W - 1) * STR_W - 2 * PAD_W + K_W + OPAD_W;
    localparam int TAPS  = ICG * K_D * K_H * K_W;
    localparam int TOTAL = C_OUT * OD * OH * OW * TAPS;

    typedef struct packed {
        logic          en;
        logic          last;
        logic [AW-1:0] in_a;
        logic [AW-1:0] wt_a;
        logic [AW-1:0] out_a;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tap_ready = 1'b0;
    logic          busy, done, tap_valid, tap_en, tap_last;
    logic [AW-1:0] in_addr, wt_addr, out_addr;
    tap_t          obs;

    int checks = 0;
    int errors = 0;

    conv_t3d_tap_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .tap_valid(tap_valid), .tap_ready(tap_ready),
        .tap_en(tap_en), .tap_last(tap_last),
        .in_addr(in_addr), .wt_addr(wt_addr), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    assign obs = tap_t'({tap_en, tap_last, in_addr, wt_addr, out_addr});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void axis(input int o, input int k, input int pad, input int str,
                                 input int n_in, output bit ok, output int idx);
        int t;
        t   = o + pad - k;
        ok  = (t >= 0) && (t % str == 0) && (t / str < n_in);
        idx = ok ? t / str : 0;
    endfunction

    // Decodes a flat transfer index into loop indices and applies the tap rules directly.
    function automatic tap_t model(input int n);
        int r, kw, kh, kd, icl, ow, oh, od, oc, ic, id, ih, iw;
        bit vd, vh, vw;
        tap_t e;
        r   = n;
        kw  = r % K_W;  r = r / K_W;
        kh  = r % K_H;  r = r / K_H;
        kd  = r % K_D;  r = r / K_D;
        icl = r % ICG;  r = r / ICG;
        ow  = r % OW;   r = r / OW;
        oh  = r % OH;   r = r / OH;
        od  = r % OD;   r = r / OD;
        oc  = r;
        ic  = (oc / OCG) * ICG + icl;
        axis(od, kd, PAD_D, STR_D, IN_D, vd, id);
        axis(oh, kh, PAD_H, STR_H, IN_H, vh, ih);
        axis(ow, kw, PAD_W, STR_W, IN_W, vw, iw);
        e.en    = vd && vh && vw;
        e.last  = (icl == ICG - 1) && (kd == K_D - 1) && (kh == K_H - 1) && (kw == K_W - 1);
        e.in_a  = e.en ? AW'(((ic * IN_D + id) * IN_H + ih) * IN_W + iw) : '0;
        e.wt_a  = e.en ? AW'((((ic * OCG + oc % OCG) * K_D + kd) * K_H + kh) * K_W + kw) : '0;
        e.out_a = AW'(((oc * OD + od) * OH + oh) * OW + ow);
        return e;
    endfunction

    // Starts a layer and scores every transfer; abort_at < 0 runs to completion.
    task automatic run_stream(input bit throttle, input int abort_at, input string tag);
        int   n = 0;
        int   cyc = 0;
        int   last_xfer = -10;
        bit   stalled = 1'b0;
        bit   finished = 1'b0;
        tap_t held = '0;
        tap_t exp;
        @(negedge clk);
        start     = 1'b1;
        tap_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " first_valid"}, 64'(tap_valid), 64'(1));
        check({tag, " busy_run"}, 64'(busy), 64'(1));
        while (!finished && cyc < 4 * TOTAL + 100) begin
            if (done) begin
                check({tag, " done_timing"}, 64'(cyc - last_xfer), 64'(1));
                check({tag, " xfer_count"}, 64'(n), 64'(TOTAL));
                check({tag, " valid_at_done"}, 64'(tap_valid), 64'(0));
                start = throttle;
                @(negedge clk);
                start = 1'b0;
                check({tag, " done_width"}, 64'(done), 64'(0));
                check({tag, " busy_after"}, 64'(busy), 64'(0));
                finished = 1'b1;
            end else begin
                if (stalled) begin
                    check({tag, " stall_valid"}, 64'(tap_valid), 64'(1));
                    check({tag, " stall_hold"}, 64'(obs), 64'(held));
                end
                start     = throttle ? 1'($urandom_range(0, 7) == 0) : 1'b0;
                tap_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tap_valid && n == abort_at) begin
                    abort     = 1'b1;
                    tap_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    check({tag, " abort_valid"}, 64'(tap_valid), 64'(0));
                    check({tag, " abort_busy"}, 64'(busy), 64'(0));
                    for (int i = 0; i < 5; i++) begin
                        check({tag, " abort_no_done"}, 64'(done), 64'(0));
                        @(negedge clk);
                    end
                    finished = 1'b1;
                end else if (tap_valid && tap_ready) begin
                    exp = model(n);
                    check({tag, " tap"}, 64'(obs), 64'(exp));
                    if (n == 0) check({tag, " t0_en"}, 64'(tap_en), 64'(0));
                    if (n == 7) begin
                        check({tag, " t7_en"}, 64'(tap_en), 64'(1));
                        check({tag, " t7_in"}, 64'(in_addr), 64'(0));
                        check({tag, " t7_wt"}, 64'(wt_addr), 64'(7));
                        check({tag, " t7_out"}, 64'(out_addr), 64'(0));
                    end
                    if (n == 9216) check({tag, " grp_out"}, 64'(out_addr), 64'(256));
                    if (n == 9223) begin
                        check({tag, " grp_en"}, 64'(tap_en), 64'(1));
                        check({tag, " grp_in"}, 64'(in_addr), 64'(48));
                    end
                    n++;
                    last_xfer = cyc;
                    stalled   = 1'b0;
                end else begin
                    stalled = tap_valid;
                    held    = obs;
                end
                if (!finished) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        start     = 1'b0;
        tap_ready = 1'b1;
        check({tag, " completed"}, 64'(finished), 64'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_taps", 64'(obs), 64'(0));
        check("reset_valid", 64'(tap_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_valid", 64'(tap_valid), 64'(0));

        run_stream(1'b0, -1, "full");
        run_stream(1'b1, -1, "throttle");
        run_stream(1'b0, 1000, "abort");
        run_stream(1'b0, 40, "restart");

        @(negedge clk);
        start     = 1'b1;
        tap_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_taps", 64'(obs), 64'(0));
        check("midrst_valid", 64'(tap_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_busy", 64'(busy), 64'(0));
            check("postrst_done", 64'(done), 64'(0));
        end
        run_stream(1'b0, 100, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_t3d_tap_scheduler.md
Name: conv_t3d_tap_scheduler

Overview:
- Loop-nest sequencer for the grouped, strided, padded 3D transposed-convolution datapath.
- On `start`, walks every output element and every contributing (input-channel, kernel-tap) pair. For each pair it emits an input address, a weight address and an output address to the MAC datapath over a valid/ready handshake.
- Marks taps that fall outside the input grid, or off-stride, as zero-contribution.
- Sits between the layer controller (`start`/`done`) and the operand fetch/accumulate pipeline.

Parameters:
- C_IN, 4, input channels
- C_OUT, 4, output channels
- GROUPS, 2, group count; must divide C_IN and C_OUT. ICG=C_IN/GROUPS, OCG=C_OUT/GROUPS.
- IN_D / IN_H / IN_W, 2 / 3 / 4, input spatial size
- K_D / K_H / K_W, 3 / 2 / 3, kernel size
- STR_D / STR_H / STR_W, 2 / 1 / 2, stride; restricted to 1, 2, 4, 8 (divide is a shift)
- PAD_D / PAD_H / PAD_W, 1 / 0 / 1, padding
- OPAD_D / OPAD_H / OPAD_W, 1 / 0 / 1, output padding; must be < stride
- AW, 16, address width
- Derived: OD=(IN_D-1)*STR_D-2*PAD_D+K_D+OPAD_D; OH and OW likewise. Defaults give 4, 4, 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only in IDLE
- abort  in  1  synchronous; returns to IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after final tap accepted
- tap_valid  out  1  tap available
- tap_ready  in  1  datapath accepts tap
- tap_en  out  1  1 = accumulate, 0 = contributes zero
- tap_last  out  1  last tap of current output element
- in_addr  out  AW  ((ic*IN_D+id)*IN_H+ih)*IN_W+iw
- wt_addr  out  AW  (((ic*OCG+ocl)*K_D+kd)*K_H+kh)*K_W+kw
- out_addr  out  AW  ((oc*OD+od)*OH+oh)*OW+ow

Behaviour:
- Reset: async to IDLE; busy=0, done=0, tap_valid=0, tap_en=0, tap_last=0, all addresses=0, all counters 0.
- FSM states:
  - IDLE: on start, go to RUN. Counters are already cleared.
  - RUN: after the tap with all counters at maximum is accepted, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start in RUN or DONE is ignored.
- Loop order, outermost first: oc, od, oh, ow, icl, kd, kh, kw.
  - g = oc/OCG; ocl = oc%OCG; ic = g*ICG+icl.
- Tap validity, per axis (depth shown):
  - t = od+PAD_D-kd, computed signed.
  - Valid if t>=0, t[log2 STR_D-1:0]==0, and (t>>log2 STR_D)<IN_D; then id = t>>log2 STR_D.
  - tap_en = AND of the three axes. When tap_en=0, in_addr and wt_addr are driven 0; out_addr is still correct.
- tap_last = (icl==ICG-1 && kd==K_D-1 && kh==K_H-1 && kw==K_W-1).
- Every candidate tap takes one transfer, including zero taps. There are exactly ICG*K_D*K_H*K_W taps per output element, so the stream is deterministic.
- Output register stage:
  - All tap_* and address outputs are registered.
  - Reload when (!tap_valid || tap_ready) in RUN; counters advance on reload.
  - While tap_valid && !tap_ready, all tap outputs hold stable.
  - First tap_valid appears 1 cycle after start is sampled.
  - Throughput is 1 tap/cycle with tap_ready held high.
- The final tap is not followed by another reload. tap_valid drops the cycle after the final transfer, coincident with done=1.
- abort, any state: next cycle IDLE, tap_valid=0, busy=0, counters cleared, no done pulse. abort takes priority over start in the same cycle.
- Reset asserted mid-run discards all state; there is no done pulse.
- Width rules:
  - Address products are computed at AW bits, unsigned, truncating.
  - Signed spatial temps are $clog2(max(O*,K*)+PAD)+2 bits.
  - Defaults must fit AW; an elaboration-time assertion checks C_IN*IN_D*IN_H*IN_W, C_IN*OCG*K_D*K_H*K_W and C_OUT*OD*OH*OW all ≤ 2**AW.

Decomposition:
- Package conv_t3d_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - derived-size constant functions (output size, log2 stride);
  - parameter legality checks.
- Sub-module conv_t3d_axis_map, instantiated three times: (o, k) → (valid, i) for one spatial axis, parameterised by IN, STR, PAD.
- Counters and the FSM stay in the top.

Test Plan:
- Defaults, tap_ready=1, start pulse:
  - exactly 512*36=18432 transfers;
  - tap_last on every 36th transfer;
  - done pulses once, the cycle after the last transfer;
  - busy=0 afterward.
- First output element (oc=0, od=oh=ow=0, icl=0):
  - transfer 0 (kd=kh=kw=0) has tap_en=0;
  - transfer 7 (kd=1, kh=0, kw=1) has tap_en=1, in_addr=0, wt_addr=7, out_addr=0.
- Group crossing: first transfer of oc=2 (transfer 256*36=9216) has out_addr=256. Its first tap_en=1 tap (the 8th transfer of that element) has in_addr=48, i.e. ic=2.
- Random tap_ready throttling (~50%):
  - outputs stable while stalled;
  - transfer sequence identical to the full-rate run;
  - no drops or duplicates, checked against a scoreboard model.
- abort asserted at transfer 1000 with tap_ready=1: tap_valid=0 next cycle, no done; a fresh start restarts at out_addr=0 with transfer 0.
- rst_n pulsed low mid-run:
  - outputs are zero immediately (async);
  - after release, busy=0;
  - start is accepted normally.
